// File: rtl/gan_frame_collector_if.sv
// Frame capture and beat-stream bus between the GAN core, the collector and the sink.
// master: the surrounding system (drives the frame, accepts beats).
// slave : the collector.
interface gan_frame_collector_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] pixel_1x1;
    logic [WIDTH-1:0] pixel_1x2;
    logic [WIDTH-1:0] pixel_1x3;
    logic [WIDTH-1:0] pixel_2x1;
    logic [WIDTH-1:0] pixel_2x2;
    logic [WIDTH-1:0] pixel_2x3;
    logic [WIDTH-1:0] pixel_3x1;
    logic [WIDTH-1:0] pixel_3x2;
    logic [WIDTH-1:0] pixel_3x3;
    logic [WIDTH-1:0] out_discriminator;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_index;
    logic             out_last;

    modport master (
        output in_valid, pixel_1x1, pixel_1x2, pixel_1x3, pixel_2x1, pixel_2x2,
               pixel_2x3, pixel_3x1, pixel_3x2, pixel_3x3, out_discriminator, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  in_valid, pixel_1x1, pixel_1x2, pixel_1x3, pixel_2x1, pixel_2x2,
               pixel_2x3, pixel_3x1, pixel_3x2, pixel_3x3, out_discriminator, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/gan_frame_collector.sv
// gan_frame_collector: captures one 3x3 Q8.24 frame plus discriminator score,
// streams the ten words out one per beat, and keeps a binarised pattern,
// circle/cross classification and real/fake decision for the captured frame.
// Optional macro GAN_COLLECT_CLAMP_EN clamps streamed pixel beats to [0, 1.0];
// the score beat and the classification results always use raw values.
//
// state  | meaning
// IDLE   | in_ready high, waiting for a frame
// STREAM | presenting beat beat_q (0-8 pixels, 9 score)
module gan_frame_collector #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] PIX_THRESH  = 32'h00800000,
    parameter logic [WIDTH-1:0] DISC_THRESH = 32'h00800000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    gan_frame_collector_if.slave bus,
    output logic [8:0]           pattern_o,
    output logic [1:0]           shape_o,
    output logic                 is_real_o,
    output logic [15:0]          frame_count_o
);
    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [8:0] CIRCLE_PAT = 9'b111101111;
    localparam logic [8:0] CROSS_PAT  = 9'b101010101;

    state_t           state_q;
    logic [3:0]       beat_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [8:0]       pattern_q;
    logic [1:0]       shape_q;
    logic             is_real_q;
    logic [15:0]      frame_count_q;
    // words_q[0] is always the beat on out_data; accepted beats shift down
    logic [WIDTH-1:0] words_q [10];

    logic [WIDTH-1:0] pix_raw [9];
    logic [WIDTH-1:0] words_d [10];
    logic [8:0]       pattern_d;
    logic [1:0]       shape_d;
    logic             is_real_d;

`ifdef GAN_COLLECT_CLAMP_EN
    localparam logic [WIDTH-1:0] ONE_Q = {{(WIDTH-25){1'b0}}, 1'b1, 24'b0};

    function automatic logic [WIDTH-1:0] clamp_unit(input logic [WIDTH-1:0] x);
        if ($signed(x) < 0)
            return '0;
        else if ($signed(x) > $signed(ONE_Q))
            return ONE_Q;
        else
            return x;
    endfunction
`endif

    // Gather raw pixels in row-major beat order
    always_comb begin
        pix_raw[0] = bus.pixel_1x1;
        pix_raw[1] = bus.pixel_1x2;
        pix_raw[2] = bus.pixel_1x3;
        pix_raw[3] = bus.pixel_2x1;
        pix_raw[4] = bus.pixel_2x2;
        pix_raw[5] = bus.pixel_2x3;
        pix_raw[6] = bus.pixel_3x1;
        pix_raw[7] = bus.pixel_3x2;
        pix_raw[8] = bus.pixel_3x3;
    end

    // Classification and stream words computed from the raw inputs at capture
    always_comb begin
        pattern_d = '0;
        for (int i = 0; i < 9; i++) begin
            pattern_d[i] = ($signed(pix_raw[i]) >= $signed(PIX_THRESH));
`ifdef GAN_COLLECT_CLAMP_EN
            words_d[i] = clamp_unit(pix_raw[i]);
`else
            words_d[i] = pix_raw[i];
`endif
        end
        words_d[9] = bus.out_discriminator;
        is_real_d  = ($signed(bus.out_discriminator) >= $signed(DISC_THRESH));
        case (pattern_d)
            CIRCLE_PAT: shape_d = 2'b01;
            CROSS_PAT:  shape_d = 2'b10;
            default:    shape_d = 2'b00;
        endcase
    end

    // Collector FSM with registered handshake and result outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            pattern_q     <= '0;
            shape_q       <= '0;
            is_real_q     <= 1'b0;
            frame_count_q <= '0;
            for (int i = 0; i < 10; i++) words_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < 10; i++) words_q[i] <= words_d[i];
                        pattern_q   <= pattern_d;
                        shape_q     <= shape_d;
                        is_real_q   <= is_real_d;
                        beat_q      <= '0;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        state_q     <= STREAM;
                    end
                end
                STREAM: begin
                    if (bus.out_ready) begin
                        if (beat_q == 4'd9) begin
                            in_ready_q    <= 1'b1;
                            out_valid_q   <= 1'b0;
                            out_last_q    <= 1'b0;
                            frame_count_q <= frame_count_q + 16'd1;
                            state_q       <= IDLE;
                        end else begin
                            for (int i = 0; i < 9; i++) words_q[i] <= words_q[i+1];
                            beat_q     <= beat_q + 4'd1;
                            out_last_q <= (beat_q == 4'd8);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = words_q[0];
    assign bus.out_index  = beat_q;
    assign bus.out_last   = out_last_q;
    assign pattern_o      = pattern_q;
    assign shape_o        = shape_q;
    assign is_real_o      = is_real_q;
    assign frame_count_o  = frame_count_q;
endmodule
